// File: rtl/mio_bus_responder.sv
// Memory/IO responder for the CPU data bus: word RAM, LED/counter/switch registers,
// and a programmable number of wait states before the one-cycle MIO_ready pulse.
module mio_bus_responder #(
  parameter int          RAM_AW        = 10,
  parameter int          WAIT_CYCLES   = 2,
  parameter logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CPU_MIO,
  input  logic        mem_w,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        MIO_ready,
  input  logic [15:0] sw_in,
  output logic [31:0] led_out
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0]  WLOAD    = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [29:0] LED_WORD = 30'h3C00_0000;
  localparam logic [29:0] CYC_WORD = 30'h3C00_0001;
  localparam logic [29:0] SW_WORD  = 30'h3C00_0002;

  state_t      state;
  logic        req_w;
  logic [29:0] req_word;
  logic [31:0] req_wdata;
  logic [3:0]  wcnt;
  logic [31:0] cyc;
  logic [31:0] ram [0:(2**RAM_AW)-1];
  logic [31:0] ram_q;

  logic              sel_ram, sel_led, sel_cyc, sel_sw, commit, rd_en;
  logic [RAM_AW-1:0] rd_idx;
  logic              unused_bits;

  assign unused_bits = ^cpu_addr[1:0];

  // Decode always works on the latched word address, never the live bus.
  assign sel_ram = (req_word[29:26] == 4'h0);
  assign sel_led = (req_word == LED_WORD);
  assign sel_cyc = (req_word == CYC_WORD);
  assign sel_sw  = (req_word == SW_WORD);
  assign commit  = (state == DONE) && req_w;

  // Read is launched on the last cycle before DONE so ram_q is stable in DONE.
  assign rd_en  = ((state == IDLE) && CPU_MIO && (WAIT_CYCLES == 0)) ||
                  ((state == WAIT) && (wcnt == 4'd0));
  assign rd_idx = (state == IDLE) ? cpu_addr[RAM_AW+1:2] : req_word[RAM_AW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      MIO_ready <= 1'b0;
      wcnt      <= 4'd0;
      req_w     <= 1'b0;
      req_word  <= '0;
      req_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (CPU_MIO) begin
            req_w     <= mem_w;
            req_word  <= cpu_addr[31:2];
            req_wdata <= cpu_wdata;
            if (WAIT_CYCLES > 0) begin
              state <= WAIT;
              wcnt  <= WLOAD;
            end else begin
              state     <= DONE;
              MIO_ready <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (wcnt == 4'd0) begin
            state     <= DONE;
            MIO_ready <= 1'b1;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        DONE: begin
          state     <= IDLE;
          MIO_ready <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          MIO_ready <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_out <= '0;
      cyc     <= '0;
    end else begin
      if (commit && sel_led) led_out <= req_wdata;
      // A counter write wins over the increment on the same edge.
      cyc <= (commit && sel_cyc) ? req_wdata : cyc + 32'd1;
    end
  end

  // RAM has no reset: contents survive a reset.
  always_ff @(posedge clk) begin
    if (commit && sel_ram) ram[req_word[RAM_AW-1:0]] <= req_wdata;
    if (rd_en) ram_q <= ram[rd_idx];
  end

  always_comb begin
    cpu_rdata = '0;
    if (MIO_ready) begin
      if (sel_ram)      cpu_rdata = ram_q;
      else if (sel_led) cpu_rdata = led_out;
      else if (sel_cyc) cpu_rdata = cyc;
      else if (sel_sw)  cpu_rdata = {16'h0, sw_in};
      else              cpu_rdata = UNMAPPED_DATA;
    end
  end

endmodule
